// File: rtl/watch_chain_reader_if.sv
// Host-side handshake and parallel result bus of the watch-chain scan master.
interface watch_chain_reader_if #(
  parameter int unsigned WDWIDTH = 133,
  parameter int unsigned WSWIDTH = 1
);
  logic               req;
  logic               busy;
  logic               valid;
  logic [WDWIDTH-1:0] watch_data;
  logic [WSWIDTH-1:0] signal_data;

  modport master (output req, input busy, input valid, input watch_data, input signal_data);
  modport slave  (input req, output busy, output valid, output watch_data, output signal_data);
endinterface

// File: rtl/watch_chain_reader.sv
// Scan master: captures the CPU watch-data and watch-signal chains in one edge,
// shifts both out serially and presents the assembled words with a valid strobe.
module watch_chain_reader #(
  parameter int unsigned WDWIDTH = 133,
  parameter int unsigned WSWIDTH = 1
) (
  input  logic                clk,
  input  logic                reset,
  watch_chain_reader_if.slave bus,
  output logic                scan_in,
  output logic [1:0]          scan_ctrl1,
  output logic [1:0]          scan_ctrl2,
  input  logic                scan_out1,
  input  logic                scan_out2
);

  localparam int unsigned CW = $clog2(WDWIDTH + 1);
  localparam logic [1:0] CTRL_IDLE    = 2'b00;
  localparam logic [1:0] CTRL_CAPTURE = 2'b01;
  localparam logic [1:0] CTRL_SHIFT   = 2'b10;

  typedef enum logic [1:0] {IDLE, CAPTURE, SHIFT, DONE} state_t;

  state_t             state;
  logic [CW-1:0]      count;
  logic               busy;
  logic               valid;
  logic [WDWIDTH-1:0] wd_sr;
  logic [WSWIDTH-1:0] ws_sr;
  logic [WDWIDTH-1:0] wd_next_c;
  logic [WSWIDTH-1:0] ws_next_c;

  // Shift-register next values; single-bit chains have no upper slice.
  generate
    if (WDWIDTH == 1) begin : g_wd1
      assign wd_next_c = scan_out1;
    end else begin : g_wdn
      assign wd_next_c = {scan_out1, wd_sr[WDWIDTH-1:1]};
    end
    if (WSWIDTH == 1) begin : g_ws1
      assign ws_next_c = scan_out2;
    end else begin : g_wsn
      assign ws_next_c = {scan_out2, ws_sr[WSWIDTH-1:1]};
    end
  endgenerate

  // FSM with outputs registered alongside the state they belong to.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      busy       <= 1'b0;
      valid      <= 1'b0;
      scan_ctrl1 <= CTRL_IDLE;
      scan_ctrl2 <= CTRL_IDLE;
      wd_sr      <= '0;
      ws_sr      <= '0;
    end else begin
      valid      <= 1'b0;
      scan_ctrl1 <= CTRL_IDLE;
      scan_ctrl2 <= CTRL_IDLE;
      unique case (state)
        IDLE: begin
          if (bus.req) begin
            state      <= CAPTURE;
            busy       <= 1'b1;
            count      <= '0;
            scan_ctrl1 <= CTRL_CAPTURE;
            scan_ctrl2 <= CTRL_CAPTURE;
          end
        end
        CAPTURE: begin
          state      <= SHIFT;
          scan_ctrl1 <= CTRL_SHIFT;
          scan_ctrl2 <= CTRL_SHIFT;
        end
        SHIFT: begin
          wd_sr <= wd_next_c;
          if (count < CW'(WSWIDTH)) begin
            ws_sr <= ws_next_c;
          end
          if (count == CW'(WDWIDTH - 1)) begin
            state <= DONE;
            valid <= 1'b1;
          end else begin
            count      <= count + CW'(1);
            scan_ctrl1 <= CTRL_SHIFT;
            // Signal chain stops once its last bit has been taken.
            scan_ctrl2 <= (count < CW'(WSWIDTH - 1)) ? CTRL_SHIFT : CTRL_IDLE;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign scan_in         = 1'b0;
  assign bus.busy        = busy;
  assign bus.valid       = valid;
  assign bus.watch_data  = wd_sr;
  assign bus.signal_data = ws_sr;

endmodule

// File: tb/tb_watch_chain_reader.sv
// Bench for watch_chain_reader: two instances (133/1 and 8/8) each driving a
// behavioural model of the CPU observation chains.
module tb_watch_chain_reader;

  localparam int unsigned WA = 133;
  localparam int unsigned SA = 1;
  localparam int unsigned WB = 8;
  localparam int unsigned SB = 8;
  localparam logic [WA-1:0] PAT  = 133'h1F_DEADBEEF_0000000C_12345678_0000001C;
  localparam logic [WA-1:0] PATB = 133'h0A_55AA55AA_00FF00FF_F0F0F0F0_13579BDF;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  int total = 0;
  int bad   = 0;

  watch_chain_reader_if #(.WDWIDTH(WA), .WSWIDTH(SA)) bus_a ();
  watch_chain_reader_if #(.WDWIDTH(WB), .WSWIDTH(SB)) bus_b ();

  logic       scan_in_a, scan_out1_a, scan_out2_a;
  logic [1:0] c1_a, c2_a;
  logic       scan_in_b, scan_out1_b, scan_out2_b;
  logic [1:0] c1_b, c2_b;

  watch_chain_reader #(.WDWIDTH(WA), .WSWIDTH(SA)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a), .scan_in(scan_in_a),
    .scan_ctrl1(c1_a), .scan_ctrl2(c2_a), .scan_out1(scan_out1_a), .scan_out2(scan_out2_a)
  );

  watch_chain_reader #(.WDWIDTH(WB), .WSWIDTH(SB)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b), .scan_in(scan_in_b),
    .scan_ctrl1(c1_b), .scan_ctrl2(c2_b), .scan_out1(scan_out1_b), .scan_out2(scan_out2_b)
  );

  // CPU chain models: capture loads DataIn, shift moves toward bit 0.
  logic [WA-1:0] wd_din_a;
  logic [WA-1:0] wd_chain_a = '0;
  logic [SA-1:0] ws_din_a;
  logic [SA-1:0] ws_chain_a = '0;
  logic [WB-1:0] wd_din_b;
  logic [WB-1:0] wd_chain_b = '0;
  logic [SB-1:0] ws_din_b;
  logic [SB-1:0] ws_chain_b = '0;

  always @(posedge clk) begin
    if (c1_a[0])      wd_chain_a <= wd_din_a;
    else if (c1_a[1]) wd_chain_a <= {scan_in_a, wd_chain_a[WA-1:1]};
    if (c2_a[0])      ws_chain_a <= ws_din_a;
    else if (c2_a[1]) ws_chain_a <= scan_in_a;
    if (c1_b[0])      wd_chain_b <= wd_din_b;
    else if (c1_b[1]) wd_chain_b <= {scan_in_b, wd_chain_b[WB-1:1]};
    if (c2_b[0])      ws_chain_b <= ws_din_b;
    else if (c2_b[1]) ws_chain_b <= {scan_in_b, ws_chain_b[SB-1:1]};
  end

  assign scan_out1_a = wd_chain_a[0];
  assign scan_out2_a = ws_chain_a[0];
  assign scan_out1_b = wd_chain_b[0];
  assign scan_out2_b = ws_chain_b[0];

  typedef struct {
    logic       req;
    logic       busy;
    logic       valid;
    logic [1:0] c1;
    logic [1:0] c2;
  } vec_t;

  vec_t vt [13];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [WA-1:0] act, input logic [WA-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int vcount;
    int vcyc0;
    int vcyc1;
    int ccount;
    int ccyc0;
    int ccyc1;
    logic [1:0] e1;
    logic [1:0] e2;

    reset      = 1'b1;
    bus_a.req  = 1'b0;
    bus_b.req  = 1'b0;
    wd_din_a   = PAT;
    ws_din_a   = 1'b1;
    wd_din_b   = 8'hA5;
    ws_din_b   = 8'h3C;
    repeat (3) tick();

    // Reset state on both instances
    chk("rst_busy_a",  bus_a.busy, 0);
    chk("rst_valid_a", bus_a.valid, 0);
    chk("rst_c1_a",    c1_a, 0);
    chk("rst_c2_a",    c2_a, 0);
    chk("rst_wd_a",    bus_a.watch_data, 0);
    chk("rst_ws_a",    bus_a.signal_data, 0);
    chk("rst_si_a",    scan_in_a, 0);
    chk("rst_busy_b",  bus_b.busy, 0);
    chk("rst_wd_b",    bus_b.watch_data, 0);
    chk("rst_ws_b",    bus_b.signal_data, 0);
    reset = 1'b0;
    repeat (2) tick();

    // 8/8 instance: per-cycle vector table, request in cycle 0
    vt[0]  = '{1'b1, 1'b0, 1'b0, 2'b00, 2'b00};
    vt[1]  = '{1'b0, 1'b1, 1'b0, 2'b01, 2'b01};
    for (int i = 2; i <= 9; i++) vt[i] = '{1'b0, 1'b1, 1'b0, 2'b10, 2'b10};
    vt[10] = '{1'b0, 1'b1, 1'b1, 2'b00, 2'b00};
    vt[11] = '{1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
    vt[12] = '{1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
    for (int c = 0; c < 13; c++) begin
      bus_b.req = vt[c].req;
      chk($sformatf("b_busy@%0d", c),  bus_b.busy,  vt[c].busy);
      chk($sformatf("b_valid@%0d", c), bus_b.valid, vt[c].valid);
      chk($sformatf("b_c1@%0d", c),    c1_b,        vt[c].c1);
      chk($sformatf("b_c2@%0d", c),    c2_b,        vt[c].c2);
      if (c == 10) begin
        chk("b_wd", bus_b.watch_data,  8'hA5);
        chk("b_ws", bus_b.signal_data, 8'h3C);
      end
      tick();
    end
    bus_b.req = 1'b0;

    // 133/1: single pulse, DataIn scrambled during shift to prove coherence
    for (int c = 0; c <= 137; c++) begin
      bus_a.req = (c == 0);
      if (c >= 2) begin
        wd_din_a = {5'($urandom), $urandom, $urandom, $urandom, $urandom};
        ws_din_a = 1'b0;
      end
      e1 = (c == 1) ? 2'b01 : (c >= 2 && c <= 134) ? 2'b10 : 2'b00;
      e2 = (c == 1) ? 2'b01 : (c == 2) ? 2'b10 : 2'b00;
      chk($sformatf("a_valid@%0d", c), bus_a.valid, (c == 135));
      chk($sformatf("a_busy@%0d", c),  bus_a.busy,  (c >= 1 && c <= 135));
      chk($sformatf("a_c1@%0d", c), c1_a, e1);
      chk($sformatf("a_c2@%0d", c), c2_a, e2);
      if (c == 135) begin
        chk("a_wd", bus_a.watch_data,  PAT);
        chk("a_ws", bus_a.signal_data, 1'b1);
      end
      tick();
    end
    wd_din_a = PAT;
    ws_din_a = 1'b1;
    repeat (3) tick();

    // Request held high for 300 cycles
    vcount = 0; vcyc0 = -1; vcyc1 = -1;
    ccount = 0; ccyc0 = -1; ccyc1 = -1;
    for (int c = 0; c < 300; c++) begin
      bus_a.req = 1'b1;
      if (bus_a.valid) begin
        if (vcount == 0) vcyc0 = c;
        if (vcount == 1) vcyc1 = c;
        vcount++;
      end
      if (c1_a == 2'b01) begin
        if (ccount == 0) ccyc0 = c;
        if (ccount == 1) ccyc1 = c;
        ccount++;
      end
      tick();
    end
    bus_a.req = 1'b0;
    chk("hold_vcount", 32'(vcount), 2);
    chk("hold_v0",     32'(vcyc0), 135);
    chk("hold_v1",     32'(vcyc1), 271);
    chk("hold_cap0",   32'(ccyc0), 1);
    chk("hold_cap1",   32'(ccyc1), 137);
    for (int i = 0; i < 200; i++) begin
      if (!bus_a.busy) break;
      tick();
    end
    chk("hold_drain", bus_a.busy, 0);
    repeat (3) tick();

    // Second pulse inside the busy period is dropped
    vcount = 0; vcyc0 = -1; ccount = 0;
    for (int c = 0; c <= 145; c++) begin
      bus_a.req = (c == 0 || c == 50);
      if (bus_a.valid) begin
        if (vcount == 0) vcyc0 = c;
        vcount++;
      end
      if (c > 1 && c1_a == 2'b01) ccount++;
      if (c == 135) chk("drop_wd", bus_a.watch_data, PAT);
      if (c == 145) chk("drop_idle", bus_a.busy, 0);
      tick();
    end
    chk("drop_vcount", 32'(vcount), 1);
    chk("drop_vcyc",   32'(vcyc0), 135);
    chk("drop_recap",  32'(ccount), 0);

    // Reset in mid-shift, then a fresh request recaptures new data
    vcount = 0; vcyc0 = -1;
    for (int c = 0; c <= 210; c++) begin
      bus_a.req = (c == 0 || c == 70);
      reset     = (c == 60);
      wd_din_a  = (c < 70) ? PAT : PATB;
      if (bus_a.valid) begin
        if (vcount == 0) vcyc0 = c;
        vcount++;
      end
      if (c == 61) begin
        chk("rst_mid_busy",  bus_a.busy, 0);
        chk("rst_mid_valid", bus_a.valid, 0);
        chk("rst_mid_c1",    c1_a, 0);
        chk("rst_mid_c2",    c2_a, 0);
        chk("rst_mid_wd",    bus_a.watch_data, 0);
        chk("rst_mid_ws",    bus_a.signal_data, 0);
        chk("rst_mid_si",    scan_in_a, 0);
      end
      if (c == 205) begin
        chk("rst_new_wd", bus_a.watch_data,  PATB);
        chk("rst_new_ws", bus_a.signal_data, 1'b1);
      end
      tick();
    end
    reset = 1'b0;
    chk("rst_vcount", 32'(vcount), 1);
    chk("rst_vcyc",   32'(vcyc0), 205);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
